// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage BTB branch predictor.
package bp_pkg;

    localparam int unsigned TAG_W = 30;
    localparam int unsigned CTR_W = 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
    } bpEntry_t;

    localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
    localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
    localparam logic [CTR_W-1:0] CTR_ST  = 2'b11;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic logic [CTR_W-1:0] ctrNext(input logic [CTR_W-1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports, one synchronous write port.
module bp_btb_table
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [INDEX_BITS-1:0] idx_f_i,
    input  logic [INDEX_BITS-1:0] idx_d_i,
    output bpEntry_t              entry_f_c,
    output bpEntry_t              entry_d_c,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] widx_i,
    input  bpEntry_t              wentry_i
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [CTR_W-1:0] ctr_q    [DEPTH];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= wentry_i.valid;
        end
    end

    // Payload fields are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]    <= wentry_i.tag;
            target_q[widx_i] <= wentry_i.target;
            ctr_q[widx_i]    <= wentry_i.ctr;
        end
    end

    always_comb begin
        entry_f_c.valid  = valid_q[idx_f_i];
        entry_f_c.tag    = tag_q[idx_f_i];
        entry_f_c.target = target_q[idx_f_i];
        entry_f_c.ctr    = ctr_q[idx_f_i];
        entry_d_c.valid  = valid_q[idx_d_i];
        entry_d_c.tag    = tag_q[idx_d_i];
        entry_d_c.target = target_q[idx_d_i];
        entry_d_c.ctr    = ctr_q[idx_d_i];
    end

endmodule

// File: rtl/fetch_branch_predictor.sv
// Fetch-stage BTB predictor with ID-side resolve, redirect and training.
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
module fetch_branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] pcF,
    input  logic        stallF,
    input  logic        stallD,
    output logic        predTakenF,
    output logic [31:0] predTargetF,
    input  logic [31:0] pcD,
    input  logic        resolveD,
    input  logic        takenD,
    input  logic [31:0] targetD,
    output logic        mispredictD,
    output logic [31:0] redirectPCD
`ifdef BP_STATS_EN
    ,
    output logic [31:0] branchCnt,
    output logic [31:0] missCnt
`endif
);

    localparam int unsigned TAG_SHIFT = INDEX_BITS + 2;

    logic [INDEX_BITS-1:0] idx_f, idx_d;
    logic [TAG_W-1:0]      tag_f, tag_d;
    bpEntry_t              entry_f, entry_d, wentry;
    logic                  hit_f, hit_d, we;
    logic                  pred_tk_q, pred_tk_d;
    logic [31:0]           pred_tgt_q, pred_tgt_d;
    logic [31:0]           pc_f_plus4, pc_d_plus4;
    logic                  unused_ok;

    assign unused_ok = stallF;

    assign idx_f = pcF[INDEX_BITS+1:2];
    assign idx_d = pcD[INDEX_BITS+1:2];
    assign tag_f = TAG_W'(pcF >> TAG_SHIFT);
    assign tag_d = TAG_W'(pcD >> TAG_SHIFT);
    assign pc_f_plus4 = pcF + 32'd4;
    assign pc_d_plus4 = pcD + 32'd4;

    bp_btb_table #(.INDEX_BITS(INDEX_BITS)) u_table (
        .clk       (clk),
        .rstN      (rstN),
        .idx_f_i   (idx_f),
        .idx_d_i   (idx_d),
        .entry_f_c (entry_f),
        .entry_d_c (entry_d),
        .we_i      (we),
        .widx_i    (idx_d),
        .wentry_i  (wentry)
    );

    assign hit_f = entry_f.valid && (entry_f.tag == tag_f);
    assign hit_d = entry_d.valid && (entry_d.tag == tag_d);

    assign predTakenF  = hit_f && entry_f.ctr[1];
    assign predTargetF = predTakenF ? entry_f.target : pc_f_plus4;

    // A predicted-taken non-branch is an alias hit and must fall through.
    always_comb begin
        mispredictD = 1'b0;
        redirectPCD = pc_d_plus4;
        if (resolveD) begin
            mispredictD = (takenD != pred_tk_q) || (takenD && (targetD != pred_tgt_q));
            if (takenD) begin
                redirectPCD = targetD;
            end
        end else if (pred_tk_q) begin
            mispredictD = 1'b1;
        end
    end

    always_comb begin
        pred_tk_d  = pred_tk_q;
        pred_tgt_d = pred_tgt_q;
        if (!stallD) begin
            pred_tk_d  = mispredictD ? 1'b0  : predTakenF;
            pred_tgt_d = mispredictD ? 32'd0 : predTargetF;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pred_tk_q  <= 1'b0;
            pred_tgt_q <= 32'd0;
        end else begin
            pred_tk_q  <= pred_tk_d;
            pred_tgt_q <= pred_tgt_d;
        end
    end

    // Training: read-modify-write of the pcD entry, suppressed while ID is held.
    always_comb begin
        we     = 1'b0;
        wentry = entry_d;
        if (!stallD) begin
            if (resolveD) begin
                if (hit_d) begin
                    we         = 1'b1;
                    wentry.ctr = ctrNext(entry_d.ctr, takenD);
                    if (takenD) begin
                        wentry.target = targetD;
                    end
                end else if (takenD) begin
                    we            = 1'b1;
                    wentry.valid  = 1'b1;
                    wentry.tag    = tag_d;
                    wentry.target = targetD;
                    wentry.ctr    = CTR_WT;
                end
            end else if (pred_tk_q && hit_d) begin
                we           = 1'b1;
                wentry.valid = 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            branch_cnt_q <= 32'd0;
            miss_cnt_q   <= 32'd0;
        end else if (!stallD) begin
            if (resolveD && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredictD && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign branchCnt = branch_cnt_q;
    assign missCnt   = miss_cnt_q;
`endif

endmodule

// File: doc/fetch_branch_predictor.md
# fetch_branch_predictor

Fetch-stage dynamic branch predictor for the pipelined MIPS core: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It predicts the next PC in IF and carries each prediction into ID alongside the instruction. When the ID-stage branch decision resolves (branch taken / jump), the block compares the outcome against that carried prediction, raises a redirect on mismatch, and trains the table. It is the fetch-side counterpart of the ID-stage branch decision logic: it produces predictions, and that logic produces the outcomes it consumes.

## Interface
- INDEX_BITS, 4: BTB index width; 2**INDEX_BITS entries, indexed by PC[INDEX_BITS+1:2].
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous, active-low reset.
- pcF  in  32  current fetch PC.
- stallF  in  1  IF stage held. The predictor has no IF-side state, so this is informational only.
- stallD  in  1  IF/ID register held; freezes the ID-side prediction registers and blocks table updates.
- predTakenF  out  1  prediction for pcF: BTB hit and counter[1]=1.
- predTargetF  out  32  predicted next PC: BTB target when predTakenF=1, else pcF+4.
- pcD  in  32  PC of the instruction now in ID.
- resolveD  in  1  the ID instruction is a branch or jump (BEQ/BNE/J).
- takenD  in  1  actual outcome: PCSrc or jump from ID.
- targetD  in  32  actual taken target computed in ID.
- mispredictD  out  1  redirect fetch and flush IF/ID.
- redirectPCD  out  32  correct next PC when mispredictD=1: targetD if takenD, else pcD+4.

## Operation
- Entry fields: valid, tag = PC[31:INDEX_BITS+2], target[31:0], ctr[1:0]. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational):
  - hit = valid && tag match at index(pcF).
  - predTakenF = hit && ctr[1].
- ID-side registers predTkD and predTgtD:
  - Load predTakenF and predTargetF on each clk edge when stallD=0.
  - Load 0 and 0 instead when mispredictD=1, because the IF instruction is on the wrong path.
- Misprediction (combinational):
  - If resolveD=1: mispredictD = (takenD != predTkD) || (takenD && targetD != predTgtD).
  - If resolveD=0 and predTkD=1 (alias hit on a non-branch): mispredictD=1, redirectPCD=pcD+4.
  - Otherwise mispredictD=0.
- Table update, committed on the clk edge only when stallD=0:
  - resolveD && hit(pcD) && takenD: ctr saturating +1, target←targetD.
  - resolveD && hit(pcD) && !takenD: ctr saturating −1.
  - resolveD && miss && takenD: allocate valid=1, tag, target=targetD, ctr=10.
  - resolveD && miss && !takenD: no allocation.
  - !resolveD && predTkD: invalidate the entry at index(pcD) if its tag matches.
- Hit for update is recomputed from pcD against current table contents.

## Timing
- Prediction: 0-cycle (same-cycle lookup). Resolution: mispredictD is combinational in ID, and the redirect takes effect on the next clk edge. Mispredict penalty: 1 cycle.
- Table writes become visible to lookups one cycle after the edge. A same-cycle lookup and update on the same index returns the old entry (no bypass).
- Reset (asynchronous, rstN=0):
  - All valid bits 0, predTkD=0, predTgtD=0.
  - Outputs during reset: predTakenF=0, predTargetF=pcF+4, mispredictD=0 (given resolveD=0).
  - An update pending when reset asserts is discarded.
- stallD=1 with resolveD=1: no update and ID registers held. The update commits once, on the first unstalled edge.
- Counter saturation: 11+1=11, 00−1=00.
- Arithmetic: pcF+4 and pcD+4 wrap modulo 2**32.

## Configuration
- BP_STATS_EN defined:
  - Adds outputs branchCnt[31:0] and missCnt[31:0].
  - branchCnt increments on each committed resolve (resolveD && !stallD). missCnt increments on each committed mispredictD.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- BP_STATS_EN undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Structure
- Package bp_pkg holds:
  - bpEntry_t packed struct (valid, tag, target, ctr).
  - Counter constants CTR_SNT, CTR_WNT, CTR_WT, CTR_ST.
  - Function ctrNext(ctr, taken).
- Sub-module bp_btb_table: entry storage, with one combinational read port for pcF, one for pcD, and one synchronous write port. Its valid bits are asynchronously reset.
- Top level holds the ID-side registers, the mispredict/redirect logic, and the optional stats counters.

## Test plan
- Reset, then pcF=0x40 → predTakenF=0, predTargetF=0x44. Asserting rstN=0 mid-run clears all entries.
- Cold taken branch: pcD=0x40, resolveD=1, takenD=1, targetD=0x80 → mispredictD=1, redirectPCD=0x80. Next cycle, pcF=0x40 gives predTakenF=1, predTargetF=0x80.
- Counter training: with the entry at 10, issue two not-taken resolves → ctr 01 then 00, and predTakenF=0. Two takens from 00 → 10, predicting taken again. Six takens hold the counter at 11.
- Target change: entry 0x40→0x80 at 11, resolve with takenD=1 and targetD=0xC0 → mispredictD=1, redirectPCD=0xC0, target updated to 0xC0.
- Alias: a non-branch at pcD=0x40 with predTkD=1 and resolveD=0 → mispredictD=1, redirectPCD=0x44, entry invalidated. Separately, a resolve held by stallD=1 for 3 cycles commits exactly one update.
- BP_STATS_EN: 10 resolves with 3 mispredicts → branchCnt=10, missCnt=3. Both read 0 after reset.
